// File: rtl/alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// alu_instr_sequencer
//
// Queues 18-bit ALU instruction words in a small FIFO and issues them to the
// ALU one at a time. Each issued word is held on instr for a fixed number of
// cycles. Ordinary instructions are held HOLD_CYCLES cycles. A multiply
// (instr[17:15] == MUL_OPCODE) is held MUL_CYCLES cycles, and check is high
// for the first CHECK_CYCLES of them. When the FIFO is not empty, the next
// word is issued on the final hold cycle, so there is no gap between
// instructions.
//
// Optional feature: define SEQ_RESULT_CAPTURE_EN to latch the ALU result and
// flags on the last hold cycle of every instruction. res_valid then pulses for
// one cycle when those registers update. Without the macro, the result
// outputs are tied to zero.
//
// Ports
//   clock, reset       sole rising-edge clock; synchronous active-high reset
//   wr_en, wr_instr    push an instruction word (dropped when full)
//   run                level; new instructions are issued only while high
//   full, empty        FIFO occupancy flags
//   wr_err             sticky; a push was attempted while full
//   instr, check       instruction and multiply-start strobe to the ALU
//   busy               an instruction is currently being held
//   alu_Y, alu_overflow, alu_Cout   ALU result inputs
//   res_Y, res_flags, res_valid     captured result / {overflow, Cout} / pulse
// ---------------------------------------------------------------------------
module alu_instr_sequencer #(
    parameter int         DEPTH        = 16,
    parameter int         HOLD_CYCLES  = 2,
    parameter int         CHECK_CYCLES = 2,
    parameter int         MUL_CYCLES   = 11,
    parameter logic [2:0] MUL_OPCODE   = 3'b110
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [17:0] wr_instr,
    input  logic        run,
    output logic        full,
    output logic        empty,
    output logic        wr_err,
    output logic [17:0] instr,
    output logic        check,
    output logic        busy,
    input  logic [15:0] alu_Y,
    input  logic        alu_overflow,
    input  logic        alu_Cout,
    output logic [15:0] res_Y,
    output logic [1:0]  res_flags,
    output logic        res_valid
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MUL_CYCLES + HOLD_CYCLES) + 1;

    // Terminal count of each timed state; MWAIT covers the rest of a multiply.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MUL_CYCLES - CHECK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, MCHK, MWAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [17:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [17:0]      instr_q;
    logic             wr_err_q;

    logic [17:0]      head;
    logic             push, pop, fin, head_is_mul;

    assign full        = (count_q == (AW+1)'(DEPTH));
    assign empty       = (count_q == '0);
    assign head        = mem_q[rd_ptr_q];
    assign head_is_mul = (head[17:15] == MUL_OPCODE);

    // Push admission uses the pre-pop occupancy: a full FIFO rejects the word
    // even if a pop happens on the same edge.
    assign push = wr_en && !full;

    // Last cycle of an instruction's hold window.
    assign fin = ((state_q == HOLD)  && (cnt_q == HOLD_LAST)) ||
                 ((state_q == MWAIT) && (cnt_q == WAIT_LAST));

    // run is only looked at here, so dropping it never shortens an instruction.
    assign pop = run && !empty && ((state_q == IDLE) || fin);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        count_d = count_q;

        case (state_q)
            IDLE:    cnt_d = '0;
            MCHK: begin
                if (cnt_q == CHK_LAST) begin
                    state_d = MWAIT;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase

        if (pop) begin
            state_d = head_is_mul ? MCHK : HOLD;
            cnt_d   = '0;
        end else if (fin) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                instr_q  <= head;
            end
            if (wr_en && full) begin
                wr_err_q <= 1'b1;
            end
        end
    end

    // Storage array carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= wr_instr;
        end
    end

    assign instr  = instr_q;
    assign wr_err = wr_err_q;
    assign check  = (state_q == MCHK);
    assign busy   = (state_q != IDLE);

`ifdef SEQ_RESULT_CAPTURE_EN
    logic [15:0] res_y_q;
    logic [1:0]  res_flags_q;
    logic        res_valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            res_y_q     <= '0;
            res_flags_q <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= fin;
            if (fin) begin
                res_y_q     <= alu_Y;
                res_flags_q <= {alu_overflow, alu_Cout};
            end
        end
    end

    assign res_Y     = res_y_q;
    assign res_flags = res_flags_q;
    assign res_valid = res_valid_q;
`else
    logic unused_alu;
    assign unused_alu = ^{alu_Y, alu_overflow, alu_Cout};
    assign res_Y      = '0;
    assign res_flags  = '0;
    assign res_valid  = 1'b0;
`endif

endmodule
